// File: rtl/sa_tile_sequencer_pkg.sv
// Shared types and phase-length helpers for the systolic-array tile sequencer.
// Latency: n/a (types and elaboration-time functions only).
// Backpressure: n/a.
package sa_tile_sequencer_pkg;

   // 3-bit state encoding, shared by the top and the enable decoder
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD_W  = 3'd1,
      SHIFT_W = 3'd2,
      LOAD_A  = 3'd3,
      STREAM  = 3'd4,
      DRAIN   = 3'd5,
      DONE    = 3'd6
   } seq_state_t;

   // one bit per strobe the sequencer drives, registered as a group
   typedef struct packed {
      logic busy;
      logic done;
      logic w_req;
      logic a_req;
      logic ibuf_load;
      logic ibuf_out;
      logic wbuf_load;
      logic wbuf_out;
      logic obuf_load;
      logic obuf_out;
      logic write_weight;
   } seq_en_t;

   // phase lengths in cycles
   function automatic int len_load_w(input int aw);
      return aw;
   endfunction

   function automatic int len_shift_w(input int aw);
      return aw;
   endfunction

   function automatic int len_load_a(input int rows);
      return rows;
   endfunction

   // activations need ARRAY_W-1 extra cycles to skew through, results ARRAY_W more
   function automatic int len_stream(input int aw, input int rows);
      return rows + 2 * aw - 1;
   endfunction

   function automatic int len_drain(input int rows);
      return rows;
   endfunction

   // input buffer feeds the array while c < stream_in_end
   function automatic int stream_in_end(input int aw, input int rows);
      return rows + aw - 1;
   endfunction

   // output buffer captures results while c >= stream_out_begin
   function automatic int stream_out_begin(input int aw);
      return 2 * aw - 1;
   endfunction

endpackage

// File: rtl/sa_seq_enable_decode.sv
// Combinational decode of (state, phase counter) into the sequencer strobe vector.
// Latency: zero; the parent feeds next-state values and registers the result.
// Backpressure: none; pure function of its inputs.
module sa_seq_enable_decode
   import sa_tile_sequencer_pkg::*;
#(
   parameter int ARRAY_W = 4,
   parameter int ROWS    = 4,
   parameter int CNT_W   = 8
) (
   input  seq_state_t       state,
   input  logic [CNT_W-1:0] cnt,
   output seq_en_t          en
);

   localparam logic [CNT_W-1:0] IN_END    = CNT_W'(stream_in_end(ARRAY_W, ROWS));
   localparam logic [CNT_W-1:0] OUT_BEGIN = CNT_W'(stream_out_begin(ARRAY_W));

   // map each phase to its buffer enables and host request strobes
   always_comb begin
      en      = '0;
      en.busy = (state != IDLE);
      case (state)
         LOAD_W: begin
            en.wbuf_load = 1'b1;
            en.w_req     = 1'b1;
         end
         SHIFT_W: begin
            en.wbuf_out     = 1'b1;
            en.write_weight = 1'b1;
         end
         LOAD_A: begin
            en.ibuf_load = 1'b1;
            en.a_req     = 1'b1;
         end
         STREAM: begin
            en.ibuf_out  = (cnt < IN_END);
            en.obuf_load = (cnt >= OUT_BEGIN);
         end
         DRAIN:   en.obuf_out = 1'b1;
         DONE:    en.done     = 1'b1;
         default: en          = '0;
      endcase
   end

endmodule

// File: rtl/sa_tile_sequencer.sv
// Tile sequencer: drives buffer/weight enables and host strobes for one systolic tile.
// Latency: first phase enable the cycle after start is accepted; all outputs registered.
// Backpressure: none; start is ignored while busy, abort returns to IDLE next cycle.
// Optional: define SA_SEQ_PERF_CNT_EN to add the perf_cycles busy-cycle counter.
module sa_tile_sequencer
   import sa_tile_sequencer_pkg::*;
#(
   parameter int ARRAY_W = 4,   // must match the ARRAYWIDTH build of the array
   parameter int ROWS    = 4,   // 1..255
   parameter int CNT_W   = 8    // must hold ROWS + 2*ARRAY_W
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic reuse_weights,
   input  logic abort,
   output logic busy,
   output logic done,
   output logic w_req,
   output logic a_req,
   output logic res_valid,
   output logic input_buffer_load_en,
   output logic input_buffer_out_en,
   output logic weight_buffer_load_en,
   output logic weight_buffer_out_en,
   output logic output_buffer_load_en,
   output logic output_buffer_out_en,
   output logic write_weight_en
`ifdef SA_SEQ_PERF_CNT_EN
   ,output logic [31:0] perf_cycles
`endif
);

   localparam logic [CNT_W-1:0] LAST_LW = CNT_W'(len_load_w(ARRAY_W) - 1);
   localparam logic [CNT_W-1:0] LAST_SW = CNT_W'(len_shift_w(ARRAY_W) - 1);
   localparam logic [CNT_W-1:0] LAST_LA = CNT_W'(len_load_a(ROWS) - 1);
   localparam logic [CNT_W-1:0] LAST_ST = CNT_W'(len_stream(ARRAY_W, ROWS) - 1);
   localparam logic [CNT_W-1:0] LAST_DR = CNT_W'(len_drain(ROWS) - 1);

   seq_state_t       state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   seq_en_t          en_nx, en_q;
   logic             res_valid_q;
   logic             start_acc;

   assign start_acc = (state == IDLE) && start && !abort;

   // next state and counter; counter clears on every state entry
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt + CNT_W'(1);
      if (state != IDLE && abort) begin
         state_nx = IDLE;
         cnt_nx   = '0;
      end else begin
         case (state)
            IDLE: begin
               cnt_nx = '0;
               if (start_acc) state_nx = reuse_weights ? LOAD_A : LOAD_W;
            end
            LOAD_W:  if (cnt == LAST_LW) begin state_nx = SHIFT_W; cnt_nx = '0; end
            SHIFT_W: if (cnt == LAST_SW) begin state_nx = LOAD_A;  cnt_nx = '0; end
            LOAD_A:  if (cnt == LAST_LA) begin state_nx = STREAM;  cnt_nx = '0; end
            STREAM:  if (cnt == LAST_ST) begin state_nx = DRAIN;   cnt_nx = '0; end
            DRAIN:   if (cnt == LAST_DR) begin state_nx = DONE;    cnt_nx = '0; end
            default: begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end
         endcase
      end
   end

   sa_seq_enable_decode #(
      .ARRAY_W (ARRAY_W),
      .ROWS    (ROWS),
      .CNT_W   (CNT_W)
   ) u_decode (
      .state (state_nx),
      .cnt   (cnt_nx),
      .en    (en_nx)
   );

   // state, counter and registered strobes; res_valid trails obuf_out by one cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         en_q        <= '0;
         res_valid_q <= 1'b0;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         en_q        <= en_nx;
         res_valid_q <= en_q.obuf_out;
      end
   end

   assign busy                  = en_q.busy;
   assign done                  = en_q.done;
   assign w_req                 = en_q.w_req;
   assign a_req                 = en_q.a_req;
   assign res_valid             = res_valid_q;
   assign input_buffer_load_en  = en_q.ibuf_load;
   assign input_buffer_out_en   = en_q.ibuf_out;
   assign weight_buffer_load_en = en_q.wbuf_load;
   assign weight_buffer_out_en  = en_q.wbuf_out;
   assign output_buffer_load_en = en_q.obuf_load;
   assign output_buffer_out_en  = en_q.obuf_out;
   assign write_weight_en       = en_q.write_weight;

`ifdef SA_SEQ_PERF_CNT_EN
   logic [31:0] perf_q;

   // busy-cycle counter: cleared on start accept, saturating, held while idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_q <= '0;
      end else if (start_acc) begin
         perf_q <= '0;
      end else if (en_q.busy && perf_q != 32'hFFFF_FFFF) begin
         perf_q <= perf_q + 32'd1;
      end
   end

   assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_sa_tile_sequencer.sv
// Scoreboard bench for sa_tile_sequencer (ARRAY_W=4, ROWS=4).
// Stimulus pushes per-cycle expected output vectors; the monitor compares at negedge.
// Expected vectors come from hand-written cycle ranges relative to the start cycle.
module tb_sa_tile_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   logic reuse_weights = 1'b0;
   logic abort = 1'b0;
   logic busy, done, w_req, a_req, res_valid;
   logic input_buffer_load_en, input_buffer_out_en;
   logic weight_buffer_load_en, weight_buffer_out_en;
   logic output_buffer_load_en, output_buffer_out_en;
   logic write_weight_en;
`ifdef SA_SEQ_PERF_CNT_EN
   logic [31:0] perf_cycles;
`endif

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int         cyc;
      logic [11:0] v;
   } exp_t;
   exp_t q[$];

   sa_tile_sequencer #(.ARRAY_W(4), .ROWS(4), .CNT_W(8)) dut (
      .clk                   (clk),
      .rst                   (rst),
      .start                 (start),
      .reuse_weights         (reuse_weights),
      .abort                 (abort),
      .busy                  (busy),
      .done                  (done),
      .w_req                 (w_req),
      .a_req                 (a_req),
      .res_valid             (res_valid),
      .input_buffer_load_en  (input_buffer_load_en),
      .input_buffer_out_en   (input_buffer_out_en),
      .weight_buffer_load_en (weight_buffer_load_en),
      .weight_buffer_out_en  (weight_buffer_out_en),
      .output_buffer_load_en (output_buffer_load_en),
      .output_buffer_out_en  (output_buffer_out_en),
      .write_weight_en       (write_weight_en)
`ifdef SA_SEQ_PERF_CNT_EN
      ,.perf_cycles          (perf_cycles)
`endif
   );

   // bit order: busy done w_req a_req res_valid ibl ibo wbl wbo obl obo ww
   logic [11:0] outv;
   assign outv = {busy, done, w_req, a_req, res_valid,
                  input_buffer_load_en, input_buffer_out_en,
                  weight_buffer_load_en, weight_buffer_out_en,
                  output_buffer_load_en, output_buffer_out_en, write_weight_en};

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // k = cycles after the start-sample cycle
   function automatic logic [11:0] exp_vec(input bit reuse, input int k);
      logic [11:0] v;
      v = '0;
      if (!reuse) begin
         v[11] = (k >= 1  && k <= 28);
         v[10] = (k == 28);
         v[9]  = (k >= 1  && k <= 4);
         v[4]  = (k >= 1  && k <= 4);
         v[3]  = (k >= 5  && k <= 8);
         v[0]  = (k >= 5  && k <= 8);
         v[8]  = (k >= 9  && k <= 12);
         v[6]  = (k >= 9  && k <= 12);
         v[5]  = (k >= 13 && k <= 19);
         v[2]  = (k >= 20 && k <= 23);
         v[1]  = (k >= 24 && k <= 27);
         v[7]  = (k >= 25 && k <= 28);
      end else begin
         v[11] = (k >= 1  && k <= 20);
         v[10] = (k == 20);
         v[8]  = (k >= 1  && k <= 4);
         v[6]  = (k >= 1  && k <= 4);
         v[5]  = (k >= 5  && k <= 11);
         v[2]  = (k >= 12 && k <= 15);
         v[1]  = (k >= 16 && k <= 19);
         v[7]  = (k >= 17 && k <= 20);
      end
      return v;
   endfunction

   task automatic push(input int c, input logic [11:0] v);
      exp_t e;
      e.cyc = c;
      e.v   = v;
      q.push_back(e);
   endtask

   task automatic push_tile(input int base, input bit reuse, input int last_k);
      for (int k = 1; k <= last_k; k++) push(base + k, exp_vec(reuse, k));
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s got=%0h required=%0h", name, got, req);
      end
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // monitor: compare whenever an expectation is due or the DUT shows activity
   always @(negedge clk) begin
      exp_t e;
      while (q.size() > 0 && q[0].cyc < cyc) begin
         e = q.pop_front();
         checks++;
         errors++;
         $display("FAIL missed cyc=%0d required=%b", e.cyc, e.v);
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
         e = q.pop_front();
         checks++;
         if (outv !== e.v) begin
            errors++;
            $display("FAIL outputs cyc=%0d got=%b required=%b", cyc, outv, e.v);
         end
      end else if (outv != 12'h000) begin
         checks++;
         errors++;
         $display("FAIL unexpected cyc=%0d got=%b required=000000000000", cyc, outv);
      end
   end

   initial begin
      int c0;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {20'd0, outv}, 32'd0);
`ifdef SA_SEQ_PERF_CNT_EN
      chk("reset_perf", perf_cycles, 32'd0);
`endif
      rst = 1'b0;
      @(negedge clk);
      chk("idle_busy", {31'd0, busy}, 32'd0);

      // full tile with weight load
      @(negedge clk);
      c0 = cyc;
      push_tile(c0, 1'b0, 29);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_to(c0 + 31);
`ifdef SA_SEQ_PERF_CNT_EN
      chk("perf_after_done", perf_cycles, 32'd28);
`endif

      // start re-pulsed at 5 and 28 is ignored; start at 29 runs a reuse tile
      @(negedge clk);
      c0 = cyc;
      push_tile(c0, 1'b0, 29);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
`ifdef SA_SEQ_PERF_CNT_EN
      chk("perf_cleared_on_accept", perf_cycles, 32'd0);
`endif
      wait_to(c0 + 5);
      start = 1'b1;
      reuse_weights = 1'b1;
      @(negedge clk);
      start = 1'b0;
      reuse_weights = 1'b0;
      wait_to(c0 + 28);
      start = 1'b1;
      @(negedge clk);
      push_tile(c0 + 29, 1'b1, 21);
      reuse_weights = 1'b1;
      @(negedge clk);
      start = 1'b0;
      reuse_weights = 1'b0;
      wait_to(c0 + 29 + 23);

      // abort in STREAM, then a fresh tile two cycles later
      @(negedge clk);
      c0 = cyc;
      push_tile(c0, 1'b0, 15);
      push(c0 + 16, 12'h000);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_to(c0 + 15);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      wait_to(c0 + 17);
`ifdef SA_SEQ_PERF_CNT_EN
      chk("perf_held_after_abort", perf_cycles, 32'd15);
`endif
      push_tile(c0 + 17, 1'b0, 29);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_to(c0 + 17 + 31);

      // abort mid-DRAIN of a reuse tile: one trailing res_valid, no done
      @(negedge clk);
      c0 = cyc;
      push_tile(c0, 1'b1, 17);
      push(c0 + 18, 12'h080);
      push(c0 + 19, 12'h000);
      start = 1'b1;
      reuse_weights = 1'b1;
      @(negedge clk);
      start = 1'b0;
      reuse_weights = 1'b0;
      wait_to(c0 + 17);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      wait_to(c0 + 21);

      // start together with abort in IDLE: nothing happens
      c0 = cyc;
      push(c0 + 1, 12'h000);
      push(c0 + 2, 12'h000);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      wait_to(c0 + 3);
`ifdef SA_SEQ_PERF_CNT_EN
      chk("perf_not_cleared_by_aborted_start", perf_cycles, 32'd17);
`endif

      // asynchronous reset in DRAIN clears outputs before the next edge
      @(negedge clk);
      c0 = cyc;
      push_tile(c0, 1'b0, 25);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_to(c0 + 25);
      #2 rst = 1'b1;
      #1 chk("async_reset_outputs", {20'd0, outv}, 32'd0);
`ifdef SA_SEQ_PERF_CNT_EN
      chk("async_reset_perf", perf_cycles, 32'd0);
`endif
      repeat (2) @(negedge clk);
      rst = 1'b0;
      c0 = cyc;
      for (int k = 1; k <= 4; k++) push(c0 + k, 12'h000);
      wait_to(c0 + 5);
      chk("idle_after_reset_busy", {31'd0, busy}, 32'd0);

      @(negedge clk);
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL leftover_expectations got=%0d required=0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
